// File: rtl/comb_cycle_relax_pkg.sv
// Shared ternary types, Kleene operators and FSM state encoding for comb_cycle_relax.
package comb_cycle_pkg;

  typedef logic [1:0] tern_t;

  localparam tern_t T0 = 2'b00;
  localparam tern_t T1 = 2'b01;
  localparam tern_t TX = 2'b10;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  function automatic tern_t t_norm(input tern_t a);
    return (a == 2'b11) ? TX : a;
  endfunction

  function automatic tern_t t_and(input tern_t a, input tern_t b);
    tern_t an;
    tern_t bn;
    an = t_norm(a);
    bn = t_norm(b);
    if (an == T0 || bn == T0)      return T0;
    else if (an == T1 && bn == T1) return T1;
    else                           return TX;
  endfunction

  function automatic tern_t t_or(input tern_t a, input tern_t b);
    tern_t an;
    tern_t bn;
    an = t_norm(a);
    bn = t_norm(b);
    if (an == T1 || bn == T1)      return T1;
    else if (an == T0 && bn == T0) return T0;
    else                           return TX;
  endfunction

endpackage

// File: rtl/comb_cycle_relax_if.sv
// Request/response handshake bundle for comb_cycle_relax; IW is derived from MAX_ITERS.
interface comb_cycle_relax_if #(
  parameter int unsigned MAX_ITERS = 8
);
  import comb_cycle_pkg::*;

  localparam int unsigned IW = $clog2(MAX_ITERS + 1);

  logic          req_valid;
  logic          req_ready;
  tern_t         req_x;
  logic          rsp_valid;
  logic          rsp_ready;
  tern_t         rsp_f;
  logic [IW-1:0] rsp_iters;
  logic          rsp_converged;

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_iters, rsp_converged
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_iters, rsp_converged
  );
endinterface

// File: rtl/comb_cycle_relax_step.sv
// One combinational relaxation step of i = x && f, f = x || i.
// COMB_CYCLE_RELAX_GAUSS_SEIDEL_EN selects Gauss-Seidel ordering (f uses the new i).
module comb_cycle_step
  import comb_cycle_pkg::*;
(
  input  tern_t x,
  input  tern_t i,
  input  tern_t f,
  output tern_t i_n,
  output tern_t f_n,
  output logic  stable
);

  assign i_n = t_and(x, f);

`ifdef COMB_CYCLE_RELAX_GAUSS_SEIDEL_EN
  assign f_n = t_or(x, i_n);
`else
  assign f_n = t_or(x, i);
`endif

  assign stable = (i_n == i) && (f_n == f);

endmodule

// File: rtl/comb_cycle_relax.sv
// Clocked ternary relaxation of the two-gate cyclic circuit; FSM, iteration counter and result regs.
// Ordering of the step is chosen by COMB_CYCLE_RELAX_GAUSS_SEIDEL_EN (see comb_cycle_step).
module comb_cycle_relax
  import comb_cycle_pkg::*;
#(
  parameter int unsigned MAX_ITERS = 8
) (
  input  logic                clk,
  input  logic                rst,
  comb_cycle_relax_if.slave   bus
);

  localparam int unsigned   IW    = $clog2(MAX_ITERS + 1);
  localparam logic [IW-1:0] LIMIT = IW'(MAX_ITERS);

  state_t        state_q, state_d;
  tern_t         x_q, i_q, f_q;
  logic [IW-1:0] iters_q;
  logic          conv_q;

  tern_t         i_n, f_n;
  logic          stable;
  logic [IW-1:0] iters_n;
  logic          done;
  logic          req_ready, rsp_valid;

  comb_cycle_step u_step (
    .x      (x_q),
    .i      (i_q),
    .f      (f_q),
    .i_n    (i_n),
    .f_n    (f_n),
    .stable (stable)
  );

  assign iters_n = iters_q + IW'(1);
  // Stability wins over the limit, so a stable final step still reports convergence.
  assign done    = stable || (iters_n == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = EVAL;
      EVAL:    if (done)          state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= TX;
      i_q     <= TX;
      f_q     <= TX;
      iters_q <= '0;
      conv_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          x_q     <= t_norm(bus.req_x);
          i_q     <= TX;
          f_q     <= TX;
          iters_q <= '0;
          conv_q  <= 1'b0;
        end
        EVAL: begin
          i_q     <= i_n;
          f_q     <= f_n;
          iters_q <= iters_n;
          conv_q  <= stable;
        end
        default: ;
      endcase
    end
  end

  // f_q already holds f' when RESP is entered, whether stable or limit-terminated.
  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_f         = f_q;
  assign bus.rsp_iters     = iters_q;
  assign bus.rsp_converged = conv_q;

endmodule
